regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port register file, successor to the single-write/dual-read core regfile.
//   Configurable width, depth and read/write port counts; registered reads with write-first bypass.
//   Hardware clear sweep after reset, so the storage needs no bulk reset and maps to LUTRAM/BRAM.
//   Sits in the core decode/writeback path; ready gates the pipeline until the clear sweep is done.
// PARAMETERS
//   XLEN      32  data width in bits
//   NREGS     32  register count; power of two, >= 2
//   NREAD      2  number of read ports, >= 1
//   NWRITE     1  number of write ports, >= 1
//   ZERO_REG   1  1: register 0 reads 0 and ignores writes; 0: register 0 is ordinary
// PORTS
//   clk     in   1                   single clock; all state updates on posedge
//   rst     in   1                   synchronous, active-high reset
//   ready   out  1                   1 = clear sweep done; reads and writes are honoured
//   wen     in   NWRITE              per-port write enable
//   wsel    in   NWRITE x log2(NREGS)  per-port write address
//   wdata   in   NWRITE x XLEN       per-port write data
//   rsel    in   NREAD x log2(NREGS)   per-port read address
//   rdata   out  NREAD x XLEN        per-port read data, registered
// BEHAVIOUR
//   Reset
//   - With rst=1 at a posedge: state<=CLEAR, clr_idx<=0, ready<=0, every rdata<=0.
//   - A reset mid-sweep or mid-operation restarts the sweep at index 0.
//   FSM (two states)
//   - CLEAR: regs[clr_idx]<=0 and clr_idx++ each cycle.
//     After clr_idx==NREGS-1 is written, go to RUN.
//     The sweep lasts exactly NREGS cycles after rst falls.
//   - RUN: ready=1. No exit except rst.
//   - While in CLEAR: wen is ignored and rdata is held at 0.
//   Write
//   - In RUN, at the posedge, regs[wsel[w]]<=wdata[w] for each w with wen[w]=1.
//   - With ZERO_REG=1, writes to address 0 are dropped.
//   - Same-address conflict between write ports: the highest-indexed port wins.
//   Read
//   - rsel is sampled at posedge N; rdata is valid after posedge N (1-cycle latency).
//   - Write-first bypass: if a write to the same address is honoured at the same posedge,
//     rdata takes that wdata, applying the same highest-port-wins rule.
//   - With ZERO_REG=1, rsel=0 always returns 0, including under bypass.
//   - Multiple read ports may read the same address; they are independent and never conflict.
//   Widths
//   - Address width is $clog2(NREGS), so no out-of-range addresses exist.
//   - clr_idx has the same width; the wrap to 0 on the final sweep increment is benign.
// STRUCTURE
//   regfile_pkg
//   - rf_state_e {RF_CLEAR, RF_RUN}.
//   - function rf_addr_w(NREGS) returning $clog2 with minimum 1.
//   Sub-module regfile_read_port, instantiated NREAD times. Each instance contains:
//   - the priority bypass mux over the NWRITE write ports;
//   - the zero-register mask;
//   - the output register, with rst and CLEAR forcing it to 0.
//   Top level: storage array, write loop (ascending w so the last, highest port wins), clear FSM.
// TESTING
//   1. Reset with NREGS=32:
//      rst high 2 cycles, then low -> ready=0 for exactly 32 cycles, then 1.
//      All 32 registers then read 0.
//   2. In RUN, write r5=0xDEADBEEF, next cycle rsel[0]=5 -> rdata[0]=0xDEADBEEF after 1 clock.
//      wen=1 with wsel=0, wdata=0x1234 (ZERO_REG=1), then read r0 -> 0.
//   3. Bypass: same cycle wen, wsel=7, wdata=0xA5A5A5A5, rsel[1]=7 -> rdata[1]=0xA5A5A5A5 next
//      cycle, not the old value.
//   4. NWRITE=2: both ports write r3, port0=0x11, port1=0x22, with rsel=3 in the same cycle
//      -> bypassed rdata=0x22; a later read of r3 gives 0x22.
//   5. rst pulsed when clr_idx=10:
//      - sweep restarts at 0; ready stays low 32 cycles after the pulse;
//      - wen during CLEAR does not modify the array (r9=0x55 attempt reads 0 after ready).
//   6. Parameter sweep XLEN=64, NREGS=16, NREAD=3, ZERO_REG=0:
//      - r0 is writable (0xFFFF_0000_FFFF_0000 reads back);
//      - all 3 ports read distinct registers in the same cycle correctly.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
//   rf_state_e : clear-sweep FSM state
//   rf_addr_w  : address width for a given register count (minimum 1 bit)
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  function automatic int unsigned rf_addr_w(input int unsigned nregs);
    int unsigned w;
    w = $clog2(nregs);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp.
//   ready : 1 once the post-reset clear sweep has finished
//   wen   : per-write-port enable           [NWRITE]
//   wsel  : per-write-port address          [NWRITE][AW]
//   wdata : per-write-port data             [NWRITE][XLEN]
//   rsel  : per-read-port address           [NREAD][AW]
//   rdata : per-read-port registered data   [NREAD][XLEN]
// master = pipeline side, slave = register file.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NWRITE = 1
) ();

  localparam int unsigned AW = rf_addr_w(NREGS);

  logic                             ready;
  logic [NWRITE-1:0]                wen;
  logic [NWRITE-1:0][AW-1:0]        wsel;
  logic [NWRITE-1:0][XLEN-1:0]      wdata;
  logic [NREAD-1:0][AW-1:0]         rsel;
  logic [NREAD-1:0][XLEN-1:0]       rdata;

  modport master (
    input  ready, rdata,
    output wen, wsel, wdata, rsel
  );

  modport slave (
    output ready, rdata,
    input  wen, wsel, wdata, rsel
  );

endinterface

// File: rtl/regfile_read_port.sv
// One registered read port of regfile_mp.
//   clk, rst  : clock, synchronous active-high reset
//   clearing  : high while the clear sweep runs; holds rdata at 0
//   rsel      : read address, sampled at the posedge
//   arr_data  : combinational array contents at rsel
//   wen/wsel/wdata : write ports as honoured this cycle (already gated to RUN)
//   rdata     : registered read data
// Write-first: a same-address write at the same edge overrides the array
// value, highest-indexed write port taking precedence.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NWRITE   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = rf_addr_w(NREGS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clearing,
  input  logic [AW-1:0]               rsel,
  input  logic [XLEN-1:0]             arr_data,
  input  logic [NWRITE-1:0]           wen,
  input  logic [NWRITE-1:0][AW-1:0]   wsel,
  input  logic [NWRITE-1:0][XLEN-1:0] wdata,
  output logic [XLEN-1:0]             rdata
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [XLEN-1:0] rd_next;

  always_comb begin
    rd_next = arr_data;
    // Ascending scan: the last matching (highest) port overrides earlier ones.
    for (int unsigned w = 0; w < NWRITE; w++) begin
      if (wen[w] && (wsel[w] == rsel)) begin
        rd_next = wdata[w];
      end
    end
    if (ZR && (rsel == '0)) begin
      rd_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clearing) begin
      rdata <= '0;
    end else begin
      rdata <= rd_next;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file.
//   clk  : single clock, all state on posedge
//   rst  : synchronous active-high reset; restarts the clear sweep
//   bus  : regfile_mp_if slave (ready, wen/wsel/wdata, rsel/rdata)
// After reset the FSM spends NREGS cycles writing zero to every register,
// then enters RUN and raises ready. The storage array itself has no reset
// so it can map onto distributed/block RAM. Writes and bypass are ignored
// until RUN; rdata is held at zero during reset and the sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned NWRITE   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_mp_if.slave   bus
);

  localparam int unsigned   AW       = rf_addr_w(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  localparam bit            ZR       = (ZERO_REG != 0);

  rf_state_e                  state;
  logic [AW-1:0]              clr_idx;
  logic                       ready_q;
  logic [XLEN-1:0]            regs [NREGS];
  logic [NWRITE-1:0]          wen_run;
  logic [NREAD-1:0][XLEN-1:0] arr_rd;
  logic [NREAD-1:0][XLEN-1:0] rd_q;

  assign bus.ready = ready_q;
  assign bus.rdata = rd_q;
  assign wen_run   = (state == RF_RUN) ? bus.wen : '0;

  // Clear-sweep FSM; ready rises together with the transition into RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RF_CLEAR;
      clr_idx <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        RF_CLEAR: begin
          clr_idx <= clr_idx + AW'(1);
          if (clr_idx == LAST_IDX) begin
            state   <= RF_RUN;
            ready_q <= 1'b1;
          end
        end
        RF_RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state   <= RF_CLEAR;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage: sweep writes during CLEAR, port writes during RUN.
  // Ascending port order makes the highest-indexed port win on conflicts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == RF_CLEAR) begin
        regs[clr_idx] <= '0;
      end else begin
        for (int unsigned w = 0; w < NWRITE; w++) begin
          if (wen_run[w] && !(ZR && (bus.wsel[w] == '0))) begin
            regs[bus.wsel[w]] <= bus.wdata[w];
          end
        end
      end
    end
  end

  always_comb begin
    arr_rd = '0;
    for (int unsigned r = 0; r < NREAD; r++) begin
      arr_rd[r] = regs[bus.rsel[r]];
    end
  end

  for (genvar r = 0; r < NREAD; r++) begin : g_rd
    regfile_read_port #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .NWRITE   (NWRITE),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .clk      (clk),
      .rst      (rst),
      .clearing (state == RF_CLEAR),
      .rsel     (bus.rsel[r]),
      .arr_data (arr_rd[r]),
      .wen      (wen_run),
      .wsel     (bus.wsel),
      .wdata    (bus.wdata),
      .rdata    (rd_q[r])
    );
  end

endmodule
